// File: rtl/sccb_pkg.sv
// Shared state encoding and timing constants for the SCCB configuration sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StLoad,
    StIssue,
    StWaitEnd,
    StCheck,
    StGap,
    StDone,
    StError
  } sccb_state_e;

  localparam logic [23:0] LUT_END_MARKER = 24'hFFFFFF;
  localparam int unsigned GAP_TICKS      = 2;
  localparam int unsigned WDOG_TICKS     = 64;

endpackage

// File: rtl/sccb_clk_div.sv
// Free-running SCL divider: i2c_clk low for the first half of the period, i2c_en strobe mid-low.
module sccb_clk_div #(
  parameter int unsigned CLK_DIV = 400
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_i2c_clk,
  output logic o_i2c_en
);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_QTR  = CW'(CLK_DIV / 4);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_i2c_clk;
  logic          r_i2c_en;

  assign w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

  // Outputs are registered from the next count so they line up with r_cnt without a comb path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_i2c_clk <= 1'b1;
      r_i2c_en  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_i2c_clk <= (w_cnt_nxt >= CNT_HALF);
      r_i2c_en  <= (w_cnt_nxt == CNT_QTR);
    end
  end

  assign o_i2c_clk = r_i2c_clk;
  assign o_i2c_en  = r_i2c_en;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a {sub_addr, data} register LUT and issues one SCCB write per entry, retrying NACKs.
// Define SCCB_CFG_READBACK_EN to follow every successful write with a verifying read.
module sccb_cfg_sequencer
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 400,
  parameter int unsigned LUT_SIZE  = 256,
  parameter logic [7:0]  SLAVE_ID  = 8'h78,
  parameter int unsigned PWRUP_DLY = 20000,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned IW       = $clog2(LUT_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  output logic [IW-1:0] o_lut_index,
  input  logic [23:0]   i_lut_data,
  output logic          o_i2c_clk,
  output logic          o_i2c_en,
  output logic [39:0]   o_i2c_wdata,
  output logic          o_wr,
  output logic          o_trans,
  input  logic          i_i2c_end,
  input  logic          i_ack,
  input  logic [7:0]    i_i2c_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [IW-1:0] o_err_index
);
  localparam int unsigned RW  = $clog2(MAX_RETRY + 2);
  localparam int unsigned WDW = $clog2(WDOG_TICKS + 1);
  localparam int unsigned GW  = $clog2(GAP_TICKS + 1);
  localparam logic [IW:0] IDX_END = (IW+1)'(LUT_SIZE);

  sccb_state_e r_state, w_state_nxt;

  // One extra bit so the index can rest at LUT_SIZE.
  logic [IW:0]     r_idx;
  logic [RW-1:0]   r_retry;
  logic [31:0]     r_dly;
  logic [WDW-1:0]  r_wdog;
  logic [GW-1:0]   r_gap;
  logic            r_fail;
  logic            r_rd_pend;
  logic [39:0]     r_wdata;
  logic            r_wr;
  logic [IW-1:0]   r_err_index;

  logic w_i2c_en;
  logic w_lut_end;
  logic w_wdog_exp;
  logic w_gap_exp;
  logic w_can_retry;
  logic w_fail_now;
  logic w_need_rd;

  sccb_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_i2c_clk(o_i2c_clk),
    .o_i2c_en (w_i2c_en)
  );

`ifdef SCCB_CFG_READBACK_EN
  assign w_fail_now = i_ack | (!r_wr && (i_i2c_rdata != r_wdata[7:0]));
  assign w_need_rd  = r_wr;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_i2c_rdata;
  assign w_fail_now     = i_ack;
  assign w_need_rd      = 1'b0;
`endif

  assign w_lut_end   = (r_idx == IDX_END) || (i_lut_data == LUT_END_MARKER);
  assign w_wdog_exp  = w_i2c_en && (r_wdog == WDW'(WDOG_TICKS - 1));
  assign w_gap_exp   = w_i2c_en && (r_gap == GW'(GAP_TICKS - 1));
  assign w_can_retry = (r_retry < RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone, StError: if (i_start) w_state_nxt = StPwrup;
      StPwrup:   if (r_dly == PWRUP_DLY - 1) w_state_nxt = StLoad;
      StLoad:    w_state_nxt = w_lut_end ? StDone : StIssue;
      StIssue:   if (w_i2c_en) w_state_nxt = StWaitEnd;
      StWaitEnd: if (i_i2c_end || w_wdog_exp) w_state_nxt = StCheck;
      StCheck:   w_state_nxt = (r_fail && !w_can_retry) ? StError : StGap;
      StGap:     if (w_gap_exp) w_state_nxt = r_rd_pend ? StIssue : StLoad;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_wdog      <= '0;
      r_gap       <= '0;
      r_fail      <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wdata     <= '0;
      r_wr        <= 1'b1;
      r_err_index <= '0;
    end else begin
      case (r_state)
        StIdle, StDone, StError: begin
          if (i_start) begin
            r_idx     <= '0;
            r_retry   <= '0;
            r_dly     <= '0;
            r_rd_pend <= 1'b0;
          end
        end
        StPwrup: r_dly <= r_dly + 32'd1;
        StLoad: begin
          if (!w_lut_end) begin
            r_wdata <= {SLAVE_ID | 8'h01, SLAVE_ID, i_lut_data};
            r_wr    <= 1'b1;
          end
        end
        StIssue: r_wdog <= '0;
        StWaitEnd: begin
          // A completion in the same cycle as watchdog expiry takes the controller's result.
          if (i_i2c_end)       r_fail <= w_fail_now;
          else if (w_wdog_exp) r_fail <= 1'b1;
          else if (w_i2c_en)   r_wdog <= r_wdog + 1'b1;
        end
        StCheck: begin
          r_gap <= '0;
          if (r_fail) begin
            if (w_can_retry) r_retry     <= r_retry + 1'b1;
            else             r_err_index <= r_idx[IW-1:0];
          end else if (w_need_rd) begin
            r_rd_pend <= 1'b1;
          end else begin
            r_retry <= '0;
            if (r_idx != IDX_END) r_idx <= r_idx + 1'b1;
          end
        end
        StGap: begin
          if (w_i2c_en) r_gap <= r_gap + 1'b1;
          if (w_gap_exp && r_rd_pend) begin
            r_wr      <= 1'b0;
            r_rd_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_trans     = (r_state == StWaitEnd) || ((r_state == StIssue) && w_i2c_en);
    o_busy      = !(r_state inside {StIdle, StDone, StError});
    o_done      = (r_state == StDone);
    o_error     = (r_state == StError);
    o_i2c_en    = w_i2c_en;
    o_lut_index = r_idx[IW-1:0];
    o_i2c_wdata = r_wdata;
    o_wr        = r_wr;
    o_err_index = r_err_index;
  end

endmodule
